// File: rtl/icache_flush_ctrl_pkg.sv
// Shared types and helpers for the icache flush controller.
package icache_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } flush_state_e;

  // Width needed to hold 0..max_out; never narrower than one bit.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/icache_outstanding_cnt.sv
// Per-port outstanding-fetch counter: +1 on accepted request, -1 on response,
// saturating at both ends.
module icache_outstanding_cnt
  import icache_flush_ctrl_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  localparam int CntW = cnt_width(MaxOutstanding)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            zero_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

  // A lone increment at the ceiling or a lone decrement at zero means the
  // monitored fetch interface broke its outstanding-transaction contract.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && (cnt_q == CntMax)));
  underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/icache_flush_ctrl.sv
// Icache flush sequencer: grant, drain masked ports, per-port flush handshake, done pulse.
// Optional cycle counter and blocking assertions under ICACHE_FLUSH_CTRL_PERF_EN.
module icache_flush_ctrl
  import icache_flush_ctrl_pkg::*;
#(
  parameter int NumFetchPorts  = 4,
  parameter int MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_req_i,
  input  logic [NumFetchPorts-1:0] flush_mask_i,
  output logic                     flush_gnt_o,
  output logic                     flush_done_o,
  output logic                     busy_o,
  input  logic [NumFetchPorts-1:0] fetch_req_i,
  input  logic [NumFetchPorts-1:0] fetch_gnt_i,
  input  logic [NumFetchPorts-1:0] fetch_rvalid_i,
  output logic [NumFetchPorts-1:0] fetch_block_o,
  output logic [NumFetchPorts-1:0] icache_flush_valid_o,
  input  logic [NumFetchPorts-1:0] icache_flush_ready_i,
  input  logic                     prefetch_en_i,
  output logic                     prefetch_en_o
`ifdef ICACHE_FLUSH_CTRL_PERF_EN
  ,
  output logic [31:0]              flush_cycles_o
`endif
);

  localparam int CntW = cnt_width(MaxOutstanding);

  flush_state_e             state_q, state_d;
  logic [NumFetchPorts-1:0] mask_q, mask_d;
  logic [NumFetchPorts-1:0] done_q, done_d;
  logic [NumFetchPorts-1:0] handshake;
  logic [NumFetchPorts-1:0] cnt_zero;
  logic [CntW-1:0]          cnt [NumFetchPorts];
  logic                     in_flush_window;

  for (genvar gi = 0; gi < NumFetchPorts; gi++) begin : g_cnt
    icache_outstanding_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (fetch_req_i[gi] & fetch_gnt_i[gi]),
      .dec_i (fetch_rvalid_i[gi]),
      .cnt_o (cnt[gi]),
      .zero_o(cnt_zero[gi])
    );

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt[gi] <= CntW'(MaxOutstanding));
  end

  assign in_flush_window = (state_q == DRAIN) || (state_q == FLUSH);

  // Reset gating keeps the grant low while the block is held in reset.
  assign flush_gnt_o          = (state_q == IDLE) & flush_req_i & ~rst_i;
  assign flush_done_o         = (state_q == DONE);
  assign busy_o               = (state_q != IDLE);
  assign fetch_block_o        = in_flush_window ? mask_q : '0;
  assign icache_flush_valid_o = (state_q == FLUSH) ? (mask_q & ~done_q) : '0;
  assign prefetch_en_o        = in_flush_window ? 1'b0 : prefetch_en_i;
  assign handshake            = icache_flush_valid_o & icache_flush_ready_i;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          mask_d  = flush_mask_i;
          done_d  = '0;
          state_d = (|flush_mask_i) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        // Uses registered counts, so a response landing this cycle is seen next cycle.
        if (~|(mask_q & ~cnt_zero)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        done_d = done_q | handshake;
        if (done_d == mask_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

`ifdef ICACHE_FLUSH_CTRL_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // The grant cycle counts as the first cycle; the value is frozen once back in IDLE.
  always_comb begin
    cycles_d = cycles_q;
    if (flush_gnt_o) begin
      cycles_d = 32'd1;
    end else if ((state_q != IDLE) && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign flush_cycles_o = cycles_q;

  no_fetch_while_flushing_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == FLUSH) |-> ~|(fetch_req_i & fetch_gnt_i & mask_q));
`endif

endmodule

// File: doc/icache_flush_ctrl.md
Name: icache_flush_ctrl

Overview:
- Sequences instruction-cache flushes for a cluster icache with N fetch ports.
- Accepts one flush command (port mask) from a requester, e.g. a cluster control-register peripheral.
- Blocks new fetches on the masked ports and drains their outstanding fetches.
- Then drives the per-port flush_valid/flush_ready handshake into the icache and signals completion.
- Disables prefetching for the whole flush.

Parameters:
NumFetchPorts, 4, number of fetch ports / flush channels (>=1)
MaxOutstanding, 2, max in-flight fetches per port; counter width CntW = $clog2(MaxOutstanding+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_req_i  in  1  flush command valid
flush_mask_i  in  NumFetchPorts  ports to flush; sampled on grant
flush_gnt_o  out  1  command accepted
flush_done_o  out  1  single-cycle completion pulse
busy_o  out  1  state != IDLE
fetch_req_i  in  NumFetchPorts  core fetch request (monitored)
fetch_gnt_i  in  NumFetchPorts  icache grant (monitored)
fetch_rvalid_i  in  NumFetchPorts  icache response valid (monitored)
fetch_block_o  out  NumFetchPorts  gates fetch_req upstream of icache
icache_flush_valid_o  out  NumFetchPorts  per-port flush request to icache
icache_flush_ready_i  in  NumFetchPorts  per-port flush acknowledge
prefetch_en_i  in  1  prefetch enable from config
prefetch_en_o  out  1  prefetch enable to icache

Behaviour:
- Reset (rst_i=1, async, active-high):
  - State IDLE; mask_q=0, done_q=0, all counters 0.
  - All outputs 0 except prefetch_en_o=prefetch_en_i.
  - Reset mid-flush abandons the flush; flush_valid drops immediately; no done pulse.
- Outstanding counter per port i:
  - +1 on fetch_req_i&fetch_gnt_i; -1 on fetch_rvalid_i.
  - Both in the same cycle: unchanged.
  - Increment at MaxOutstanding or decrement at 0: counter holds (assertion fires).
  - Counters run in all states.
- FSM states IDLE, DRAIN, FLUSH, DONE. Exactly one command in flight; no queueing.
- IDLE:
  - flush_gnt_o = flush_req_i (combinational). On grant, mask_q<=flush_mask_i, done_q<=0.
  - Mask nonzero: go to DRAIN. Mask all-zero: go directly to DONE.
- DRAIN:
  - fetch_block_o = mask_q; prefetch_en_o = 0.
  - A grant in the IDLE grant cycle is counted and drained.
  - When every masked port's counter is 0, go to FLUSH. Evaluated on the registered counter; a same-cycle rvalid that zeroes a counter is visible the next cycle.
- FLUSH:
  - fetch_block_o = mask_q; prefetch_en_o = 0.
  - icache_flush_valid_o[i] = mask_q[i] & ~done_q[i]; valid stays high until ready (no retraction).
  - On valid&ready, set done_q[i]. Ports complete independently, in any order or simultaneously.
  - When (done_q | handshakes this cycle) == mask_q, go to DONE.
- DONE:
  - flush_done_o = 1 for exactly one cycle.
  - fetch_block_o = 0; prefetch_en_o = prefetch_en_i.
  - Go to IDLE. flush_gnt_o = 0 in this state, so a back-to-back request is granted the following cycle.
- Outside DRAIN/FLUSH: fetch_block_o = 0, icache_flush_valid_o = 0.
- Minimum latency (no outstanding fetches, ready tied high): grant cycle 0, DRAIN 1, FLUSH 2, done pulse cycle 3.
- flush_mask_i and flush_req_i changing after grant have no effect until next IDLE.

Optional Feature:
ICACHE_FLUSH_CTRL_PERF_EN
- Defined: adds output flush_cycles_o[31:0].
  - Counts cycles from grant through DONE inclusive; reset 0.
  - Cleared on each grant; holds its value after DONE; saturates at 2^32-1.
  - Adds assertions that no ungated fetch_req_i&fetch_gnt_i occurs on a blocked port in FLUSH.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package icache_flush_ctrl_pkg:
  - State enum flush_state_e {IDLE, DRAIN, FLUSH, DONE} (2-bit).
  - Counter-width function.
- Sub-module icache_outstanding_cnt, one instance per port:
  - Parameter MaxOutstanding.
  - Inputs inc/dec; outputs cnt and zero.
  - Contains the saturation assertion.

Test Plan:
- Idle flush: NumFetchPorts=4, mask=4'b1111, no fetches, ready tied high -> gnt at cycle 0, flush_valid=4'b1111 at cycle 2, done pulse at cycle 3, busy_o low at cycle 4.
- Drain: port 1 has 2 fetches outstanding, mask=4'b0010 -> block[1]=1 and flush_valid stays 0 until the second rvalid; flush_valid[1] rises the cycle after the counter reaches 0.
- Staggered ready: mask=4'b0101, ready[0] at cycle +3, ready[2] at cycle +7 -> valid[0] drops after cycle +3; valid[2] held until +7; single done pulse at +8.
- Zero mask: mask=0 -> grant, done pulse next cycle; never asserts block or flush_valid; prefetch_en_o tracks prefetch_en_i throughout.
- Reset mid-FLUSH: rst_i pulsed while flush_valid=4'b0011 -> all outputs 0 asynchronously; no done pulse; next request is granted normally.
- Simultaneous inc/dec on port 0 at count 1 -> count stays 1; DRAIN persists until a lone rvalid.
